// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              accept_c;
    logic              xfer_c;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    assign accept_c = in_valid && in_ready_q && !flush;
    assign xfer_c   = out_valid_q && out_ready;

    // Main/skid occupancy; flush keeps data untouched and only kills control.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (xfer_c && accept_c) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (xfer_c) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end else if (accept_c) begin
                        state_d     = ST_TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end
                end
                ST_TWO: begin
                    if (xfer_c) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign in_ready = in_ready_q;
`else
    logic in_ready_c;

    // Single entry: space exists when empty or when the held entry leaves this cycle.
    assign in_ready_c = !out_valid_q || out_ready;
    assign accept_c   = in_valid && in_ready_c && !flush;
    assign xfer_c     = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
            main_ctrl_d = '0;
        end else if (accept_c) begin
            out_valid_d = 1'b1;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end else if (xfer_c) begin
            out_valid_d = 1'b0;
            main_ctrl_d = '0;
        end
    end

    assign in_ready = in_ready_c;
`endif

    // Back-pressure counter: clear wins, saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

endmodule
